// File: rtl/bus_initiator.sv
// Master-side port of the shared addr/data/ctrl peripheral bus: turns single-word client
// requests into a strobed bus access with a ready timeout, then reports ack/error.
module bus_initiator #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        req_ack,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] bus_addr,
    output logic        bus_r,
    output logic        bus_w,
    input  logic        bus_ready,
    output logic [31:0] bus_wdata,
    output logic        bus_wdata_oe,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Last ACCESS cycle index before abort; unused when TIMEOUT is 0 (wait forever).
    localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TO_W-1:0] TO_LAST = TO_LAST_I[TO_W-1:0];

    state_t            state_r, state_s;
    logic              we_r, we_s;
    logic [31:0]       addr_r, addr_s;
    logic [31:0]       wdata_r, wdata_s;
    logic [TO_W-1:0]   count_r, count_s;
    logic              timeout_hit_s;

    logic              busy_r, busy_s;
    logic              ack_r, ack_s;
    logic              err_r, err_s;
    logic [31:0]       rdata_r, rdata_s;
    logic [31:0]       bus_addr_r, bus_addr_s;
    logic              bus_r_r, bus_r_s;
    logic              bus_w_r, bus_w_s;
    logic [31:0]       bus_wdata_r, bus_wdata_s;
    logic              oe_r, oe_s;

    assign timeout_hit_s = (TIMEOUT != 0) && (count_r == TO_LAST);

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_s     = state_r;
        we_s        = we_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        count_s     = count_r;
        busy_s      = 1'b0;
        ack_s       = 1'b0;
        err_s       = err_r;
        rdata_s     = rdata_r;
        bus_addr_s  = 32'd0;
        bus_r_s     = 1'b0;
        bus_w_s     = 1'b0;
        bus_wdata_s = 32'd0;
        oe_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    we_s        = req_we;
                    addr_s      = req_addr;
                    wdata_s     = req_wdata;
                    count_s     = {TO_W{1'b0}};
                    state_s     = ST_ACCESS;
                    busy_s      = 1'b1;
                    bus_addr_s  = req_addr;
                    bus_r_s     = ~req_we;
                    bus_w_s     = req_we;
                    oe_s        = req_we;
                    bus_wdata_s = req_wdata;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                busy_s = 1'b1;
                if (bus_ready) begin
                    // Ready wins over a timeout landing on the same cycle.
                    if (!we_r) begin
                        rdata_s = bus_rdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    err_s   = 1'b0;
                    ack_s   = 1'b1;
                    state_s = ST_DONE;
                end else if (timeout_hit_s) begin
                    err_s   = 1'b1;
                    ack_s   = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    count_s     = count_r + {{(TO_W-1){1'b0}}, 1'b1};
                    state_s     = ST_ACCESS;
                    bus_addr_s  = addr_r;
                    bus_r_s     = ~we_r;
                    bus_w_s     = we_r;
                    oe_s        = we_r;
                    bus_wdata_s = wdata_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs; reset aborts any transfer without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            we_r        <= 1'b0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            count_r     <= {TO_W{1'b0}};
            busy_r      <= 1'b0;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            rdata_r     <= 32'd0;
            bus_addr_r  <= 32'd0;
            bus_r_r     <= 1'b0;
            bus_w_r     <= 1'b0;
            bus_wdata_r <= 32'd0;
            oe_r        <= 1'b0;
        end else begin
            state_r     <= state_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            count_r     <= count_s;
            busy_r      <= busy_s;
            ack_r       <= ack_s;
            err_r       <= err_s;
            rdata_r     <= rdata_s;
            bus_addr_r  <= bus_addr_s;
            bus_r_r     <= bus_r_s;
            bus_w_r     <= bus_w_s;
            bus_wdata_r <= bus_wdata_s;
            oe_r        <= oe_s;
        end
    end

    assign busy         = busy_r;
    assign req_ack      = ack_r;
    assign rsp_err      = err_r;
    assign rsp_rdata    = rdata_r;
    assign bus_addr     = bus_addr_r;
    assign bus_r        = bus_r_r;
    assign bus_w        = bus_w_r;
    assign bus_wdata    = bus_wdata_r;
    assign bus_wdata_oe = oe_r;

endmodule

// File: tb/tb_bus_initiator.sv
// Scoreboard bench for bus_initiator: driver pushes expected responses, a negedge monitor
// pops and compares on every ack and checks strobe/address behaviour every cycle.
module tb_bus_initiator;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        busy, req_ack, rsp_err;
    logic [31:0] rsp_rdata, bus_addr, bus_wdata;
    logic        bus_r, bus_w, bus_wdata_oe;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    bus_initiator #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .req_ack(req_ack), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .bus_addr(bus_addr), .bus_r(bus_r), .bus_w(bus_w),
        .bus_ready(bus_ready), .bus_wdata(bus_wdata), .bus_wdata_oe(bus_wdata_oe),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          cycles;
        int          issue_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] model_rdata = 32'd0;
    int          cur_delay = 0;
    logic [31:0] cur_rdata = 32'd0;
    bit          held = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave responder: ready rises after cur_delay strobe cycles; garbage data otherwise.
    int resp_scnt = 0;
    always @(posedge clk) begin
        #1;
        if (bus_r | bus_w) begin
            bus_ready = (resp_scnt == cur_delay);
            bus_rdata = bus_ready ? cur_rdata : $urandom;
            resp_scnt++;
        end else begin
            resp_scnt = 0;
            bus_ready = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
        end
    end

    // Monitor: per-cycle bus rules and scoreboard pop on each ack.
    int   mon_scnt = 0;
    bit   prev_ack = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mon_scnt = 0;
            prev_ack = 1'b0;
        end else begin
            chk("strobe_excl", 32'(bus_r & bus_w), 32'd0);
            chk("oe_eq_w", 32'(bus_wdata_oe), 32'(bus_w));
            if (bus_r | bus_w) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    chk("bus_addr", bus_addr, exp_q[0].addr);
                    chk("strobe_dir", 32'({bus_r, bus_w}), 32'({~exp_q[0].we, exp_q[0].we}));
                    if (exp_q[0].we) chk("bus_wdata", bus_wdata, exp_q[0].wdata);
                end
                mon_scnt++;
            end else begin
                chk("idle_addr", bus_addr, 32'd0);
            end
            if (req_ack) begin
                chk("ack_single", 32'(prev_ack), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("spurious_ack", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                    chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                    chk("strobe_cycles", 32'(mon_scnt), 32'(mon_e.cycles));
                    chk("ack_cycle", 32'(cyc), 32'(mon_e.issue_cyc + mon_e.cycles + 1));
                end
                mon_scnt = 0;
            end
            prev_ack = req_ack;
        end
    end

    // One transaction: wait for IDLE (unless req is still held), issue, model, await ack.
    task automatic txn(input bit we_i, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int dly, input bit keep);
        exp_t e;
        int   n;
        if (held) begin
            e.issue_cyc = cyc + 1;
        end else begin
            n = 0;
            while (busy && n < 100) begin
                @(posedge clk); #1; n++;
            end
            if (busy) chk("idle_wait", 32'd1, 32'd0);
            e.issue_cyc = cyc;
        end
        req = 1'b1; req_we = we_i; req_addr = a; req_wdata = wd;
        cur_delay = dly; cur_rdata = rd;
        e.we = we_i; e.addr = a; e.wdata = wd;
        e.err = (TIMEOUT != 0) && (dly >= TIMEOUT);
        e.cycles = e.err ? TIMEOUT : dly + 1;
        if (!e.err && !we_i) model_rdata = rd;
        e.rdata = model_rdata;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!req_ack && n < 200);
        if (!req_ack) chk("ack_wait", 32'd1, 32'd0);
        held = keep;
        if (!keep) begin
            req = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, dly;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_strobes", 32'({bus_r, bus_w, bus_wdata_oe}), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        txn(1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
        txn(1'b1, 32'h000C_0000, 32'h1234_5678, 32'hFFFF_0000, 0, 1'b0);
        txn(1'b0, 32'h0000_0020, 32'd0, 32'hCAFE_F00D, 3, 1'b0);
        txn(1'b0, 32'h0000_0030, 32'd0, 32'h1111_2222, 40, 1'b0);
        txn(1'b0, 32'h0000_0034, 32'd0, 32'h3333_4444, TIMEOUT - 1, 1'b0);
        txn(1'b1, 32'h0000_0038, 32'hA5A5_5A5A, 32'd0, TIMEOUT, 1'b0);

        // Reset in the second ACCESS cycle: outstanding transfer dropped, no ack afterwards.
        while (busy) begin @(posedge clk); #1; end
        req = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040; cur_delay = 40;
        begin
            exp_t e;
            e.we = 1'b0; e.addr = 32'h0000_0040; e.wdata = 32'd0; e.rdata = model_rdata;
            e.err = 1'b0; e.cycles = 0; e.issue_cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_rdata = 32'd0;
        chk("midrst_strobes", 32'({bus_r, bus_w, bus_wdata_oe}), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ack", 32'(req_ack), 32'd0);
        chk("midrst_rdata", rsp_rdata, 32'd0);
        repeat (25) begin @(posedge clk); #1; end
        held = 1'b0;

        txn(1'b0, 32'h0000_0100, 32'd0, 32'h0BAD_F00D, 1, 1'b0);
        for (int i = 0; i < 4; i++)
            txn(1'b0, 32'h0000_0200 + 32'(i * 4), 32'd0, $urandom, 0, (i != 3));

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            dly = (r < 7) ? $urandom_range(0, 3) : $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
            txn(1'($urandom), $urandom, $urandom, $urandom, dly, 1'($urandom));
        end
        req = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
